// File: rtl/audio_frame_scheduler_pkg.sv
// Shared constants and state encodings for the UART-fed stereo audio frame scheduler.
package audio_frame_scheduler_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] MIDSCALE  = 16'h8000;

    typedef enum logic [2:0] {
        HUNT,
        L_LO,
        L_HI,
        R_LO,
        R_HI
    } framer_state_t;

    typedef enum logic {
        PRIME,
        PLAY
    } play_state_t;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an exact occupancy count; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (fill != '0);
    assign do_push = push && ((fill != FW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                fill <= fill + FW'(1);
            else if (do_pop && !do_push)
                fill <= fill - FW'(1);
        end
    end

    // NOTE: the storage array is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Deframes A5-headed stereo frames from a UART byte stream into a FIFO and releases them
// to the DACs at the sample rate, with priming, underrun and overrun handling.
module audio_frame_scheduler
    import audio_frame_scheduler_pkg::*;
#(
    parameter int         CLOCK_FREQ  = 12_000_000,
    parameter int         SAMPLE_RATE = 48_000,
    parameter int         DEPTH       = 16,
    parameter int         START_LEVEL = DEPTH / 2,
    parameter logic [7:0] SYNC        = SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic                     dac_ce,
    output logic [15:0]              sample_l,
    output logic [15:0]              sample_r,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     playing,
    output logic                     locked,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     sync_err
);

    localparam int DIV = CLOCK_FREQ / SAMPLE_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int FW  = $clog2(DEPTH) + 1;

    framer_state_t fstate;
    play_state_t   pstate;
    logic [15:0]   l_word;
    logic [7:0]    r_lo;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          push;
    logic          pop;
    logic          full;
    frame_t        din;
    frame_t        dout;

    assign tick = (cnt == '0);
    assign push = rx_valid && (fstate == R_HI) && !reset;
    assign pop  = tick && (pstate == PLAY) && (fill != '0);
    assign full = (fill == FW'(DEPTH));
    assign din  = '{left: l_word, right: {rx_byte, r_lo}};

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .fill  (fill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate   <= HUNT;
            locked   <= 1'b0;
            sync_err <= 1'b0;
            l_word   <= '0;
            r_lo     <= '0;
        end else begin
            sync_err <= 1'b0;
            if (rx_valid) begin
                case (fstate)
                    HUNT: begin
                        if (rx_byte == SYNC) begin
                            fstate <= L_LO;
                        end else if (locked) begin
                            sync_err <= 1'b1;
                            locked   <= 1'b0;
                        end
                    end
                    L_LO: begin
                        l_word[7:0] <= rx_byte;
                        fstate      <= L_HI;
                    end
                    L_HI: begin
                        l_word[15:8] <= rx_byte;
                        fstate       <= R_LO;
                    end
                    R_LO: begin
                        r_lo   <= rx_byte;
                        fstate <= R_HI;
                    end
                    R_HI: begin
                        fstate <= HUNT;
                        locked <= 1'b1;
                    end
                    default: fstate <= HUNT;
                endcase
            end
        end
    end

    // A tick only decides; dac_ce and the popped samples appear together one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= CW'(DIV - 1);
            dac_ce   <= 1'b0;
            pstate   <= PRIME;
            playing  <= 1'b0;
            sample_l <= MIDSCALE;
            sample_r <= MIDSCALE;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            cnt      <= tick ? CW'(DIV - 1) : cnt - CW'(1);
            dac_ce   <= tick;
            underrun <= 1'b0;
            overrun  <= push && full && !pop;
            if (tick) begin
                case (pstate)
                    PRIME: begin
                        if (fill >= FW'(START_LEVEL)) begin
                            pstate  <= PLAY;
                            playing <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (fill == '0) begin
                            underrun <= 1'b1;
                            pstate   <= PRIME;
                            playing  <= 1'b0;
                        end else begin
                            sample_l <= dout.left;
                            sample_r <= dout.right;
                        end
                    end
                    default: pstate <= PRIME;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler: framing, pacing, priming, underrun, overrun and reset.
module tb_audio_frame_scheduler;

    localparam int DIV   = 250;
    localparam int DEPTH = 16;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        dac_ce;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic [4:0]  fill;
    logic        playing;
    logic        locked;
    logic        underrun;
    logic        overrun;
    logic        sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int underrun_cnt = 0;
    int overrun_cnt = 0;
    int sync_err_cnt = 0;

    vec_t tbl [16];

    audio_frame_scheduler #(
        .CLOCK_FREQ  (12_000_000),
        .SAMPLE_RATE (48_000),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .dac_ce   (dac_ce),
        .sample_l (sample_l),
        .sample_r (sample_r),
        .fill     (fill),
        .playing  (playing),
        .locked   (locked),
        .underrun (underrun),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (underrun) underrun_cnt <= underrun_cnt + 1;
        if (overrun)  overrun_cnt  <= overrun_cnt + 1;
        if (sync_err) sync_err_cnt <= sync_err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_byte(8'hA5);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
        send_byte(r[7:0]);
        send_byte(r[15:8]);
    endtask

    // Returns just after the edge on which dac_ce rises; a missing pulse counts as a failure.
    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 2 * DIV && !got; i++) begin
            step();
            if (dac_ce) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_timeout: got no dac_ce expected one within %0d cycles", 2 * DIV);
        end
    endtask

    // Strobes an A5 during reset so a framer that sees it would misdecode the next frame.
    task automatic do_reset();
        reset    = 1'b1;
        rx_byte  = 8'hA5;
        rx_valid = 1'b1;
        step();
        step();
        rx_valid = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{16'h1234, 16'h5678, 16'h1234, 16'h5678};
        tbl[1]  = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[2]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[3]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        tbl[4]  = '{16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00};
        tbl[5]  = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
        tbl[6]  = '{16'h0001, 16'h8001, 16'h0001, 16'h8001};
        tbl[7]  = '{16'hC3A5, 16'hA5C3, 16'hC3A5, 16'hA5C3};
        tbl[8]  = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
        tbl[9]  = '{16'h3333, 16'h4444, 16'h3333, 16'h4444};
        tbl[10] = '{16'h5555, 16'h6666, 16'h5555, 16'h6666};
        tbl[11] = '{16'h9999, 16'hAAAA, 16'h9999, 16'hAAAA};
        tbl[12] = '{16'hBBBB, 16'hCCCC, 16'hBBBB, 16'hCCCC};
        tbl[13] = '{16'hDDDD, 16'hEEEE, 16'hDDDD, 16'hEEEE};
        tbl[14] = '{16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0};
        tbl[15] = '{16'h7E81, 16'h817E, 16'h7E81, 16'h817E};

        // Reset state and idle pacing.
        do_reset();
        check("rst_fill", 32'(fill), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_dac_ce", 32'(dac_ce), 0);
        check("rst_sample_l", 32'(sample_l), 32'h8000);
        check("rst_sample_r", 32'(sample_r), 32'h8000);
        wait_tick();
        begin
            int n = 0;
            do begin
                step();
                n++;
                if (n == 1) check("idle_dac_ce_one_cycle", 32'(dac_ce), 0);
            end while (!dac_ce && n < 2 * DIV);
            check("idle_dac_ce_period", n, DIV);
        end
        check("idle_sample_l", 32'(sample_l), 32'h8000);
        check("idle_sample_r", 32'(sample_r), 32'h8000);
        check("idle_playing", 32'(playing), 0);

        // Eight identical frames: prime, play out, underrun.
        for (int i = 0; i < 8; i++) send_frame(16'h1234, 16'h5678);
        check("prime_fill", 32'(fill), 8);
        check("prime_locked", 32'(locked), 1);
        check("prime_playing", 32'(playing), 0);
        wait_tick();
        check("start_playing", 32'(playing), 1);
        check("start_no_pop", 32'(sample_l), 32'h8000);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            check("play_l", 32'(sample_l), 32'h1234);
            check("play_r", 32'(sample_r), 32'h5678);
            check("play_fill", 32'(fill), 32'(7 - i));
        end
        wait_tick();
        check("underrun_pulse", 32'(underrun), 1);
        check("underrun_playing", 32'(playing), 0);
        check("underrun_hold_l", 32'(sample_l), 32'h1234);
        check("underrun_hold_r", 32'(sample_r), 32'h5678);
        step();
        check("underrun_one_cycle", 32'(underrun), 0);
        check("underrun_count", underrun_cnt, 1);

        // Sync loss and re-alignment.
        do_reset();
        send_byte(8'hFF);
        check("unlocked_no_sync_err", 32'(sync_err), 0);
        wait_tick();
        send_frame(16'h0001, 16'h0002);
        check("sync_locked", 32'(locked), 1);
        send_byte(8'hFF);
        check("sync_err_pulse", 32'(sync_err), 1);
        check("sync_lock_drop", 32'(locked), 0);
        step();
        check("sync_err_one_cycle", 32'(sync_err), 0);
        send_frame(16'hABCD, 16'hEF01);
        check("relock", 32'(locked), 1);
        check("relock_fill", 32'(fill), 2);
        for (int i = 1; i < 7; i++) send_frame(tbl[i].l, tbl[i].r);
        wait_tick();
        wait_tick();
        check("resync_f0_l", 32'(sample_l), 32'h0001);
        check("resync_f0_r", 32'(sample_r), 32'h0002);
        wait_tick();
        check("resync_f1_l", 32'(sample_l), 32'hABCD);
        check("resync_f1_r", 32'(sample_r), 32'hEF01);
        check("sync_err_count", sync_err_cnt, 1);

        // Overrun with playback stalled, then push+pop on a full PLAY tick.
        do_reset();
        wait_tick();
        for (int i = 0; i < DEPTH; i++) send_frame(tbl[i].l, tbl[i].r);
        check("full_fill", 32'(fill), DEPTH);
        check("full_no_overrun", 32'(overrun), 0);
        send_frame(16'hDEAD, 16'hBEEF);
        check("overrun_pulse", 32'(overrun), 1);
        check("overrun_fill", 32'(fill), DEPTH);
        step();
        check("overrun_one_cycle", 32'(overrun), 0);
        wait_tick();
        check("full_playing", 32'(playing), 1);
        check("full_no_pop_fill", 32'(fill), DEPTH);
        for (int i = 0; i < DIV - 5; i++) step();
        send_frame(16'h7777, 16'h8888);
        check("pushpop_dac_ce", 32'(dac_ce), 1);
        check("pushpop_fill", 32'(fill), DEPTH);
        check("pushpop_no_overrun", 32'(overrun), 0);
        check("overrun_count", overrun_cnt, 1);
        check("drain_l_0", 32'(sample_l), 32'(tbl[0].exp_l));
        check("drain_r_0", 32'(sample_r), 32'(tbl[0].exp_r));
        for (int i = 1; i < DEPTH; i++) begin
            wait_tick();
            check("drain_l", 32'(sample_l), 32'(tbl[i].exp_l));
            check("drain_r", 32'(sample_r), 32'(tbl[i].exp_r));
        end
        wait_tick();
        check("drain_last_l", 32'(sample_l), 32'h7777);
        check("drain_last_r", 32'(sample_r), 32'h8888);
        wait_tick();
        check("drain_underrun", 32'(underrun), 1);

        // Reset mid-frame discards buffered and partial frames.
        do_reset();
        wait_tick();
        send_frame(16'h1111, 16'h2222);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check("midrst_fill", 32'(fill), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_sample_l", 32'(sample_l), 32'h8000);
        check("midrst_sample_r", 32'(sample_r), 32'h8000);
        wait_tick();
        send_frame(16'h4321, 16'h8765);
        for (int i = 1; i < 8; i++) send_frame(tbl[i].l, tbl[i].r);
        check("post_rst_fill", 32'(fill), 8);
        wait_tick();
        wait_tick();
        check("post_rst_l", 32'(sample_l), 32'h4321);
        check("post_rst_r", 32'(sample_r), 32'h8765);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_frame_scheduler.md
AUDIO_FRAME_SCHEDULER -- requirements
Module: audio_frame_scheduler

Interface
REQ-001 Parameter CLOCK_FREQ, default 12_000_000: system clock frequency in Hz.
REQ-002 Parameter SAMPLE_RATE, default 48_000: DAC sample rate in Hz; DIV = CLOCK_FREQ/SAMPLE_RATE (integer, >= 4).
REQ-003 Parameter DEPTH, default 16: FIFO depth in stereo frames; power of two, >= 4.
REQ-004 Parameter START_LEVEL, default DEPTH/2: fill level that starts playback; range 1..DEPTH.
REQ-005 Parameter SYNC, default 8'hA5: frame header byte.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 rx_byte  input  8  received UART byte; valid only when rx_valid=1.
REQ-009 rx_valid  input  1  one-cycle strobe, one byte per strobe; no backpressure.
REQ-010 dac_ce  output  1  one-cycle sample-rate strobe for the DACs.
REQ-011 sample_l / sample_r  output  16 each  unsigned samples presented to the DACs.
REQ-012 fill  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 playing  output  1  1 while the playback FSM is in PLAY.
REQ-014 locked  output  1  1 while the byte framer is frame-aligned.
REQ-015 underrun / overrun / sync_err  output  1 each  one-cycle event pulses.

Function
REQ-016 Framer FSM states HUNT, L_LO, L_HI, R_LO, R_HI; advances only on cycles with rx_valid=1.
REQ-017 HUNT: byte==SYNC -> L_LO; any other byte -> stays in HUNT, and if locked=1, pulses sync_err and clears locked.
REQ-018 L_LO/L_HI/R_LO/R_HI each capture one byte, LSB first; R_HI returns to HUNT and completes the frame {L,R}.
REQ-019 Frame completion sets locked=1 and requests a push in the same cycle the R_HI byte is taken.
REQ-020 Pacing counter runs DIV-1 down to 0 and reloads. dac_ce is registered, high for exactly 1 of every DIV cycles, and never stalls.
REQ-021 Playback FSM states PRIME, PLAY. PRIME -> PLAY when fill >= START_LEVEL on a tick cycle.
REQ-022 A tick cycle is the cycle in which the counter is 0. The pop decision is made on that cycle. dac_ce and the new sample_l/sample_r become visible together on the following cycle (latency 1).
REQ-023 PLAY tick with fill>0: pop the head frame into sample_l/sample_r.
REQ-024 PLAY tick with fill==0: hold the previous samples, pulse underrun, go to PRIME.
REQ-025 PRIME: no pops; samples hold their last value; dac_ce keeps pulsing.
REQ-026 Push is accepted if fill<DEPTH, or if a pop occurs in the same cycle. Otherwise the frame is dropped, overrun pulses, and FIFO contents are unchanged.
REQ-027 Simultaneous push and pop leaves fill unchanged. A push into an empty FIFO on a tick cycle still counts as empty for that tick (underrun, per REQ-024).
REQ-028 Read/write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. fill is exact and never exceeds DEPTH.
REQ-029 Frame count is preserved: frames written = frames popped + frames resident, except frames dropped under REQ-026.

Reset
REQ-030 Reset values: framer HUNT, locked=0, playback PRIME, playing=0, fill=0, pointers 0, counter DIV-1, dac_ce=0, sample_l=sample_r=16'h8000 (midscale), all event pulses 0.
REQ-031 Reset asserted mid-frame discards the partial frame and all buffered frames. A byte strobed in the same cycle as reset is ignored.
REQ-032 FIFO RAM contents need no reset.

Structure
REQ-033 SYNC default, framer/playback state encodings and midscale constant 16'h8000 belong in a shared audio package/include.
REQ-034 One sub-module, sync_fifo (parameters WIDTH=32, DEPTH; ports push/pop/din/dout/fill), instantiated once. Framer, pacing and playback logic stay in the top module.

Verification
REQ-035 DIV=250, idle input: dac_ce pulses every 250 cycles; outputs stay 16'h8000; playing=0.
REQ-036 Send A5 34 12 78 56 eight times (DEPTH 16): playback starts at the first tick after fill=8; outputs become L=16'h1234, R=16'h5678 one cycle after the tick; after 8 ticks, underrun pulses once, outputs hold, state is PRIME.
REQ-037 Send A5 01 00 02 00 FF A5 ...: sync_err pulses on FF, locked drops, and the next A5 re-aligns; the frame after FF is accepted intact.
REQ-038 With playback stalled, send 17 frames into DEPTH 16: fill=16, overrun pulses exactly once, and the 17th frame never appears at the outputs.
REQ-039 A frame completes on a PLAY tick with fill=16: push and pop both accepted, fill stays 16, no overrun.
REQ-040 Reset asserted after byte L_HI of a frame: fill=0, outputs 16'h8000; the following complete frame is decoded correctly.
